// File: rtl/sha1_msg_feeder_pkg.sv
// Shared constants, types and the last-word padding helper for the SHA-1 message feeder.
package sha1_pkg;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int FRAME_LEN       = 80;
  localparam int PHASE_LEN       = 20;
  localparam int MAX_MSG_BYTES   = 55;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    FULL,
    SENDING
  } bank_state_t;

  // Keeps the first nbytes big-endian bytes and places the 0x80 marker right after them.
  function automatic word_t pad_word(input word_t data, input logic [2:0] nbytes);
    word_t w;
    case (nbytes)
      3'd0:    w = 32'h8000_0000;
      3'd1:    w = {data[31:24], 24'h80_0000};
      3'd2:    w = {data[31:16], 16'h8000};
      3'd3:    w = {data[31:8], 8'h80};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha1_msg_feeder_if.sv
// Write-side word stream into the SHA-1 message feeder.
interface sha1_msg_feeder_if;
  import sha1_pkg::*;

  word_t      in_data;
  logic       in_valid;
  logic       in_last;
  logic [2:0] in_bytes;
  logic       in_ready;
  logic       in_err;

  modport master (
    output in_data, in_valid, in_last, in_bytes,
    input  in_ready, in_err
  );

  modport slave (
    input  in_data, in_valid, in_last, in_bytes,
    output in_ready, in_err
  );

endinterface

// File: rtl/sha1_msg_feeder_pad_bank.sv
// One 16x32 message block buffer: clear on first beat, padded last-word write, length word.
module sha1_pad_bank
  import sha1_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  word_t      wr_data,
  input  logic       wr_last,
  input  logic [2:0] wr_bytes,
  input  word_t      len_bits,
  input  logic [3:0] rd_idx,
  output word_t      rd_data
);

  word_t mem_q [WORDS_PER_BLOCK];
  word_t mem_d [WORDS_PER_BLOCK];

  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) mem_d[i] = '0;
    end
    if (wr_en) begin
      if (wr_last) begin
        mem_d[wr_idx] = pad_word(wr_data, wr_bytes);
        // A full last word pushes the 0x80 marker into the next word.
        if (wr_bytes >= 3'd4) mem_d[wr_idx + 4'd1] = 32'h8000_0000;
        mem_d[WORDS_PER_BLOCK-1] = len_bits;
      end else begin
        mem_d[wr_idx] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/sha1_msg_feeder.sv
// SHA-1 message feeder: pads short messages into double-buffered blocks and plays them
// out on the fixed 80-cycle frame as load7 / phase_advance7 / dout.
//
// bank state | meaning
// FREE       | empty, may accept the first beat of a message
// FILLING    | message beats arriving
// FULL       | padded block waiting for the next frame start
// SENDING    | block being played out on pos 0..15
module sha1_msg_feeder
  import sha1_pkg::*;
#(
  parameter int FRAME_LEN = sha1_pkg::FRAME_LEN,
  parameter int PHASE_LEN = sha1_pkg::PHASE_LEN
) (
  input  logic             clk,
  input  logic             rst,
  sha1_msg_feeder_if.slave msg,
  output logic             load7,
  output logic             phase_advance7,
  output word_t            dout
);

  localparam int POS_W = $clog2(FRAME_LEN);
  localparam int PH_W  = $clog2(PHASE_LEN);
  localparam logic [POS_W-1:0] POS_LAST     = POS_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0] POS_FREE     = POS_W'(WORDS_PER_BLOCK);
  localparam logic [POS_W-1:0] POS_LAST_LD  = POS_W'(WORDS_PER_BLOCK - 1);
  localparam logic [PH_W-1:0]  PH_LAST      = PH_W'(PHASE_LEN - 1);
  localparam logic [3:0]       IDX_LIMIT    = 4'(MAX_MSG_BYTES / 4);

  logic [POS_W-1:0] pos_q, pos_d;
  logic [PH_W-1:0]  phase_cnt_q, phase_cnt_d;
  bank_state_t      bank_st_q [2];
  bank_state_t      bank_st_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;
  logic             drop_q, drop_d;
  logic             load7_q, load7_d;
  logic             phase_advance7_q, phase_advance7_d;
  word_t            dout_q, dout_d;
  logic             in_err_q, in_err_d;

  logic             in_ready_c;
  logic             beat;
  logic             wr_free;
  logic [3:0]       wr_idx;
  logic [2:0]       eff_bytes;
  logic [6:0]       msg_len;
  logic             reject;
  logic             start_send;
  logic [1:0]       bank_clr;
  logic [1:0]       bank_wr;
  word_t            len_bits;
  word_t            rd_data [2];

  assign in_ready_c = !rst && (bank_st_q[wr_ptr_q] == FREE || bank_st_q[wr_ptr_q] == FILLING);
  assign beat       = msg.in_valid && in_ready_c;
  assign wr_free    = (bank_st_q[wr_ptr_q] == FREE);
  assign wr_idx     = wr_free ? 4'd0 : beat_cnt_q;
  assign eff_bytes  = (msg.in_bytes > 3'd4) ? 3'd4 : msg.in_bytes;
  assign msg_len    = {1'b0, wr_idx, 2'b00} + {4'b0, eff_bytes};
  assign len_bits   = 32'({msg_len, 3'b000});
  // A non-last beat at word 13 already implies at least 56 bytes.
  assign reject     = msg.in_last ? (msg_len > 7'(MAX_MSG_BYTES)) : (wr_idx >= IDX_LIMIT);
  assign start_send = (pos_q == POS_LAST) && (bank_st_q[rd_ptr_q] == FULL);

  always_comb begin
    pos_d       = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
    phase_cnt_d = (phase_cnt_q == '0 || pos_q == POS_LAST) ? PH_LAST : phase_cnt_q - 1'b1;
    bank_st_d   = bank_st_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    drop_d      = drop_q;
    in_err_d    = 1'b0;
    bank_clr    = '0;
    bank_wr     = '0;

    if (start_send) bank_st_d[rd_ptr_q] = SENDING;
    if (pos_q == POS_FREE && bank_st_q[rd_ptr_q] == SENDING) begin
      bank_st_d[rd_ptr_q] = FREE;
      rd_ptr_d            = !rd_ptr_q;
    end

    if (beat) begin
      if (drop_q) begin
        if (msg.in_last) drop_d = 1'b0;
      end else if (reject) begin
        bank_st_d[wr_ptr_q] = FREE;
        in_err_d            = 1'b1;
        drop_d              = !msg.in_last;
        beat_cnt_d          = '0;
      end else begin
        bank_wr[wr_ptr_q]  = 1'b1;
        bank_clr[wr_ptr_q] = wr_free;
        beat_cnt_d         = wr_idx + 4'd1;
        if (msg.in_last) begin
          bank_st_d[wr_ptr_q] = FULL;
          wr_ptr_d            = !wr_ptr_q;
        end else begin
          bank_st_d[wr_ptr_q] = FILLING;
        end
      end
    end

    load7_d          = start_send || (load7_q && pos_q != POS_LAST_LD);
    dout_d           = load7_q ? rd_data[rd_ptr_q] : '0;
    phase_advance7_d = (phase_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q            <= '0;
      phase_cnt_q      <= PH_LAST;
      bank_st_q[0]     <= FREE;
      bank_st_q[1]     <= FREE;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      beat_cnt_q       <= '0;
      drop_q           <= 1'b0;
      load7_q          <= 1'b0;
      phase_advance7_q <= 1'b0;
      dout_q           <= '0;
      in_err_q         <= 1'b0;
    end else begin
      pos_q            <= pos_d;
      phase_cnt_q      <= phase_cnt_d;
      bank_st_q        <= bank_st_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      beat_cnt_q       <= beat_cnt_d;
      drop_q           <= drop_d;
      load7_q          <= load7_d;
      phase_advance7_q <= phase_advance7_d;
      dout_q           <= dout_d;
      in_err_q         <= in_err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sha1_pad_bank u_bank (
      .clk      (clk),
      .clr      (bank_clr[b]),
      .wr_en    (bank_wr[b]),
      .wr_idx   (wr_idx),
      .wr_data  (msg.in_data),
      .wr_last  (msg.in_last),
      .wr_bytes (eff_bytes),
      .len_bits (len_bits),
      .rd_idx   (pos_q[3:0]),
      .rd_data  (rd_data[b])
    );
  end

  assign msg.in_ready   = in_ready_c;
  assign msg.in_err     = in_err_q;
  assign load7          = load7_q;
  assign phase_advance7 = phase_advance7_q;
  assign dout           = dout_q;

endmodule

// File: tb/tb_sha1_msg_feeder.sv
// Directed bench for sha1_msg_feeder: padding, framing, ordering, rejection and reset abort.
module tb_sha1_msg_feeder;
  import sha1_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  load7;
  logic  pa7;
  word_t dout;

  sha1_msg_feeder_if bus ();

  sha1_msg_feeder #(.FRAME_LEN(80), .PHASE_LEN(20)) dut (
    .clk            (clk),
    .rst            (rst),
    .msg            (bus),
    .load7          (load7),
    .phase_advance7 (pa7),
    .dout           (dout)
  );

  always #5 clk = ~clk;

  int    tb_pos = 0;
  int    tb_cyc = 0;
  int    n_checks = 0;
  int    n_err = 0;
  int    acc_cyc = 0;
  word_t msg_w [16];
  word_t exp_w [16];

  // Reference frame position, independent of the DUT.
  always @(posedge clk) begin
    tb_cyc <= tb_cyc + 1;
    if (rst) tb_pos <= 0;
    else     tb_pos <= (tb_pos == 79) ? 0 : tb_pos + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 16; k++) exp_w[k] = '0;
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input word_t d, input logic last, input logic [2:0] nb);
    int g = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.in_bytes = nb;
    while (!bus.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    acc_cyc = tb_cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input int nb, input logic [2:0] lb);
    for (int k = 0; k < nb; k++)
      send_beat(msg_w[k], (k == nb - 1), (k == nb - 1) ? lb : 3'd4);
  endtask

  // Waits for a frame, checks load7 over pos 0..15 and dout against exp_w; ends at pos 16.
  task automatic expect_block(input string tag, output int start);
    int g = 0;
    while (!load7 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_start"}, 32'(load7), 32'd1);
    check({tag, "_pos0"}, 32'(tb_pos), 32'd0);
    start = tb_cyc;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_load%0d", tag, k), 32'(load7), 32'd1);
      @(negedge clk);
      check($sformatf("%s_w%0d", tag, k), dout, exp_w[k]);
    end
    check({tag, "_load_end"}, 32'(load7), 32'd0);
  endtask

  task automatic watch_idle(input string tag, input int n);
    logic saw = 1'b0;
    repeat (n) begin
      if (load7 || dout != '0) saw = 1'b1;
      @(negedge clk);
    end
    check(tag, 32'(saw), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_a, s_b, s_c, s_x, g;

    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_bytes = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_load7", 32'(load7), 32'd0);
    check("rst_pa7", 32'(pa7), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_err", 32'(bus.in_err), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Idle frame: phase pulses only, no data.
    for (int i = 0; i < 80; i++) begin
      check($sformatf("pa7_c%0d", i), 32'(pa7), 32'((tb_pos % 20) == 19));
      check($sformatf("idle_load_c%0d", i), 32'(load7), 32'd0);
      check($sformatf("idle_dout_c%0d", i), dout, 32'd0);
      @(negedge clk);
    end

    // "This is a test.\n"
    msg_w[0] = 32'h5468_6973; msg_w[1] = 32'h2069_7320;
    msg_w[2] = 32'h6120_7465; msg_w[3] = 32'h7374_2e0a;
    send_msg(4, 3'd4);
    clear_exp();
    exp_w[0] = 32'h5468_6973; exp_w[1] = 32'h2069_7320;
    exp_w[2] = 32'h6120_7465; exp_w[3] = 32'h7374_2e0a;
    exp_w[4] = 32'h8000_0000; exp_w[15] = 32'h0000_0080;
    expect_block("test16", s_x);

    // "abc" with a junk fourth byte that must be overwritten by 0x80.
    msg_w[0] = 32'h6162_63EE;
    send_msg(1, 3'd3);
    clear_exp();
    exp_w[0] = 32'h6162_6380; exp_w[15] = 32'h0000_0018;
    expect_block("abc", s_x);

    // Zero-length message.
    msg_w[0] = 32'hDEAD_BEEF;
    send_msg(1, 3'd0);
    clear_exp();
    exp_w[0] = 32'h8000_0000;
    expect_block("zero", s_x);

    // 5-byte message spanning two words.
    msg_w[0] = 32'h0102_0304; msg_w[1] = 32'h05AA_BBCC;
    send_msg(2, 3'd1);
    clear_exp();
    exp_w[0] = 32'h0102_0304; exp_w[1] = 32'h0580_0000; exp_w[15] = 32'h0000_0028;
    expect_block("five", s_x);

    // 55 bytes: largest message that fits one block.
    for (int k = 0; k < 16; k++) msg_w[k] = 32'h0101_0101 * 32'(k + 1);
    send_msg(14, 3'd3);
    clear_exp();
    for (int k = 0; k < 13; k++) exp_w[k] = 32'h0101_0101 * 32'(k + 1);
    exp_w[13] = 32'h0E0E_0E80; exp_w[15] = 32'h0000_01B8;
    expect_block("len55", s_x);

    // 56 bytes: rejected on the last beat.
    send_msg(14, 3'd4);
    check("len56_err", 32'(bus.in_err), 32'd1);
    @(negedge clk);
    check("len56_err_pulse", 32'(bus.in_err), 32'd0);
    watch_idle("len56_no_frame", 100);
    msg_w[0] = 32'h6162_6300;
    send_msg(1, 3'd3);
    clear_exp();
    exp_w[0] = 32'h6162_6380; exp_w[15] = 32'h0000_0018;
    expect_block("after56", s_x);

    // Overlong message rejected mid-stream: remaining beats dropped through in_last.
    for (int k = 0; k < 16; k++) msg_w[k] = 32'h1111_1111 * 32'(k + 1);
    for (int k = 0; k < 13; k++) send_beat(msg_w[k], 1'b0, 3'd4);
    send_beat(msg_w[13], 1'b0, 3'd4);
    check("drop_err", 32'(bus.in_err), 32'd1);
    check("drop_ready", 32'(bus.in_ready), 32'd1);
    send_beat(msg_w[14], 1'b0, 3'd4);
    check("drop_err_pulse", 32'(bus.in_err), 32'd0);
    send_beat(msg_w[15], 1'b1, 3'd3);
    check("drop_last_no_err", 32'(bus.in_err), 32'd0);
    watch_idle("drop_no_frame", 100);
    msg_w[0] = 32'h4142_0000;
    send_msg(1, 3'd2);
    clear_exp();
    exp_w[0] = 32'h4142_8000; exp_w[15] = 32'h0000_0010;
    expect_block("after_drop", s_x);

    // Three back-to-back messages.
    send_beat(32'hA1A2_A3A4, 1'b1, 3'd4);
    send_beat(32'hB1B2_B3B4, 1'b1, 3'd2);
    check("bb_ready_low", 32'(bus.in_ready), 32'd0);
    clear_exp();
    exp_w[0] = 32'hA1A2_A3A4; exp_w[1] = 32'h8000_0000; exp_w[15] = 32'h0000_0020;
    expect_block("bb_a", s_a);
    check("bb_ready_pos16", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("bb_ready_pos17", 32'(bus.in_ready), 32'd1);
    check("bb_dout_zero", dout, 32'd0);
    send_beat(32'hC1C2_C3C4, 1'b1, 3'd1);
    clear_exp();
    exp_w[0] = 32'hB1B2_8000; exp_w[15] = 32'h0000_0010;
    expect_block("bb_b", s_b);
    check("bb_b_next_frame", 32'(s_b - s_a), 32'd80);
    clear_exp();
    exp_w[0] = 32'hC180_0000; exp_w[15] = 32'h0000_0008;
    expect_block("bb_c", s_c);
    check("bb_c_next_frame", 32'(s_c - s_b), 32'd80);

    // Last beat at pos 79: FULL on the pos-0 edge, so this frame stays idle.
    g = 0;
    while (tb_pos != 79 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("p79_reached", 32'(tb_pos), 32'd79);
    send_beat(32'h1234_5678, 1'b1, 3'd4);
    check("p79_not_this_frame", 32'(load7), 32'd0);
    clear_exp();
    exp_w[0] = 32'h1234_5678; exp_w[1] = 32'h8000_0000; exp_w[15] = 32'h0000_0020;
    expect_block("p79", s_x);
    check("p79_delay", 32'(s_x - acc_cyc), 32'd81);

    // Reset in the middle of a send aborts it and restarts the frame.
    send_beat(32'hD0D1_D2D3, 1'b1, 3'd4);
    g = 0;
    while (!(load7 && tb_pos == 8) && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("rs_sending", 32'(load7), 32'd1);
    rst = 1'b1;
    #1;
    check("rs_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("rs_load7", 32'(load7), 32'd0);
    check("rs_dout", dout, 32'd0);
    rst = 1'b0;
    g = 0;
    while (!pa7 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("rs_pos_restart", 32'(g), 32'd19);
    watch_idle("rs_aborted", 100);
    send_beat(32'h7A00_0000, 1'b1, 3'd1);
    clear_exp();
    exp_w[0] = 32'h7A80_0000; exp_w[15] = 32'h0000_0008;
    expect_block("rs_recover", s_x);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sha1_msg_feeder.md
# sha1_msg_feeder

Upstream stage of the SHA-1 `cycle` / `contgen_cycle` pair. It accepts short messages as a stream of 32-bit words and applies SHA-1 padding and the length word. It double-buffers complete 16-word blocks and plays them out on the fixed 80-cycle frame. It generates `load7`, `phase_advance7` and the one-cycle-delayed data word `dout` that `contgen_cycle` and `cycle` consume.

## Interface
- Parameters:
- `FRAME_LEN`, 80: cycles per compression frame.
- `PHASE_LEN`, 20: cycles per round phase.
- Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous reset, active-high.
- `in_data`  in  32  message word, big-endian: byte 0 is in [31:24].
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  marks the final word of the message.
- `in_bytes`  in  3  valid bytes in the last word, 0..4. Ignored unless `in_last`.
- `in_ready`  out  1  the write side can take a word.
- `in_err`  out  1  one-cycle pulse when a message is rejected.
- `load7`  out  1  to `contgen_cycle`: a block word is being loaded.
- `phase_advance7`  out  1  to `contgen_cycle`: phase boundary.
- `dout`  out  32  to `cycle` Din: the block word, one cycle after its `load7`.

## Operation
- Frame counter `pos` is free-running, 0..79, wraps 79→0, and resets to 0.
- `phase_advance7` = (`pos` mod 20 == 19), every frame, independent of data.
- Two banks of 16 words each. Each bank is in one of four states: FREE, FILLING, FULL, SENDING.
  - The write pointer and read pointer each toggle between the banks, so messages leave in arrival order.
- Write side:
  - `in_ready` = 1 when the write-pointer bank is FREE or FILLING.
  - A transfer happens when `in_valid && in_ready`.
  - The first beat moves the bank FREE→FILLING and zero-clears all 16 words.
  - Beat k writes word k.
  - On the `in_last` beat:
    - total bytes L = 4·(beats−1) + `in_bytes`.
    - Byte L gets 0x80.
    - All later bytes of words 0..14 are zero.
    - Word 14 = 0; word 15 = 8·L.
    - The bank becomes FULL and the write pointer toggles.
- Rejection:
  - L > 55 cannot be padded into one block.
  - A beat at word index 13 that has `in_last`=0, or has `in_last` with `in_bytes`=4, is dropped.
  - That bank returns to FREE and `in_err` pulses.
  - The write side then ignores beats until the next `in_last` (inclusive), keeping `in_ready`=1.
- `in_bytes` = 0 on a last beat contributes no bytes. A zero-length message (single beat, `in_last`, `in_bytes`=0) is legal: word 0 = 0x80000000, word 15 = 0.
- Read side:
  - At `pos`==0, if the read-pointer bank is FULL, it becomes SENDING.
  - `load7`=1 for `pos` 0..15 of that frame. On `pos`==15, `dout`←word 15.
  - At `pos`==16 the bank becomes FREE and the read pointer toggles.
  - If no bank is FULL at `pos`==0, the frame is idle: `load7`=0.
- Simultaneous events:
  - A bank that turns FULL on the same edge where `pos`==0 is not sent until the next frame.
  - A bank freed at `pos`==16 may start FILLING on the following cycle.

## Timing
- All outputs are registered except `in_ready`, which is combinational from bank state and `rst`.
- `dout` in the cycle after `load7` for `pos`=k equals word k.
- `dout` = 0 whenever the previous cycle had `load7`=0.
- Reset values:
  - `pos`=0, banks FREE, both pointers at bank 0.
  - `load7`=0, `phase_advance7`=0, `dout`=0, `in_err`=0.
  - `in_ready`=0 while `rst` is high, and 1 on the first cycle after.
- Reset mid-fill or mid-send aborts everything: partial data is discarded and the next frame starts at `pos`=0.
- Latency: the last beat accepted at cycle t. First `load7` comes at the first `pos`==0 strictly after t+1, which is at most 80 cycles later. First word appears on `dout` one cycle after that.
- Throughput: one block per 80 cycles. With both banks occupied, `in_ready` stays low until `pos`==16.

## Structure
- Package `sha1_pkg` holds:
  - constants `WORDS_PER_BLOCK`=16, `FRAME_LEN`, `PHASE_LEN`, `MAX_MSG_BYTES`=55.
  - `bank_state_t` enum (FREE, FILLING, FULL, SENDING).
  - `word_t` typedef.
- Sub-module `sha1_pad_bank`: one 16×32 bank with clear, byte-lane masked write, 0x80/zero insertion and length-word write. It is instantiated twice.
- The top holds the frame counter, bank state machines and pointers.

## Test plan
- Message "This is a test.\n": 4 beats, `in_bytes`=4 on last.
  - Required `dout` words: 54686973, 20697320, 61207465, 73742e0a, then 80000000, then words 5..14 = 0, then 00000080.
  - `load7` high `pos` 0..15; `phase_advance7` at `pos` 19/39/59/79.
- 3-byte message 0x616263 (one beat, `in_bytes`=3) → word 0 = 61626380, word 15 = 00000018.
- 55-byte message (14 beats, last `in_bytes`=3) → word 13 = xxxxxx80, word 15 = 000001B8.
  - 56-byte message → `in_err` pulse, no frame sent, next message accepted normally.
- Three back-to-back messages:
  - `in_ready` falls after the second is FULL and rises one cycle after `pos`==16.
  - Blocks go out in order in consecutive frames.
- Last beat accepted exactly at `pos`==79 → bank FULL at `pos`==0, sent the next frame, not this one.
  - Also: assert `rst` at `pos`==8 of a send → `load7`/`dout` drop to 0 and `pos` restarts at 0.
